// File: rtl/conv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// conv_ctrl_pkg
// Shared definitions for the conv layer controllers.
//   - DEF_DATA_W / DEF_ADDR_W : default parameter-word and weight-address widths
//   - state_e                 : controller state encoding (IDLE, LOAD, RUN,
//                               CHECK, ERR); CHECK/ERR are only reachable when
//                               the loader is built with WEIGHT_CHECKSUM_EN.
// -----------------------------------------------------------------------------
package conv_ctrl_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/conv_weight_loader_if.sv
// -----------------------------------------------------------------------------
// conv_weight_loader_if
// Bundles the parameter word stream (upstream DMA/FIFO side) and the conv
// weight-write port.
//   s_data / s_valid / s_ready : word stream, beat on s_valid && s_ready
//   weight_wr_data/addr/en     : one-cycle write strobe into the conv
// Modports:
//   slave  : the loader (consumes the stream, drives the write port)
//   master : the environment (drives the stream, observes the write port)
// -----------------------------------------------------------------------------
interface conv_weight_loader_if
  import conv_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] weight_wr_data;
  logic [ADDR_W-1:0] weight_wr_addr;
  logic              weight_wr_en;

  modport slave (
    input  s_data, s_valid,
    output s_ready, weight_wr_data, weight_wr_addr, weight_wr_en
  );

  modport master (
    output s_data, s_valid,
    input  s_ready, weight_wr_data, weight_wr_addr, weight_wr_en
  );

endinterface

// File: rtl/conv_weight_loader_wload_csum.sv
// -----------------------------------------------------------------------------
// wload_csum
// Running modulo-2^DATA_W sum of the parameter words of one layer load, with a
// compare against the trailing checksum word.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : zero the sum (start of a load)
//   acc_en   : add data into the sum this cycle
//   data     : word to accumulate, or the checksum word to compare against
//   match    : current sum equals data
// -----------------------------------------------------------------------------
module wload_csum
  import conv_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              acc_en,
  input  logic [DATA_W-1:0] data,
  output logic              match
);

  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (clr) begin
      sum_q <= '0;
    end else if (acc_en) begin
      sum_q <= sum_q + data;
    end
  end

  assign match = (sum_q == data);

endmodule

// File: rtl/conv_weight_loader.sv
// -----------------------------------------------------------------------------
// conv_weight_loader
// Sequences one conv layer: streams NUM_WORDS parameter words into the conv
// weight-write port at BASE_ADDR, BASE_ADDR+1, ... and then opens the
// activation path (act_valid_in -> act_valid_out, conv_rd_en -> act_rd_en).
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   start                      : begin a (re)load; wins over clear
//   clear                      : RUN -> IDLE
//   bus (slave)                : word stream in, weight-write port out
//   act_valid_in / act_rd_en   : activation FIFO side
//   act_valid_out / conv_rd_en : conv side
//   busy                       : loading (LOAD or CHECK)
//   load_done                  : RUN, activation open
//   chk_err                    : checksum mismatch (WEIGHT_CHECKSUM_EN only)
// Build option: define WEIGHT_CHECKSUM_EN to require a trailing checksum word
// (sum of the words mod 2^DATA_W) before the activation path opens.
// -----------------------------------------------------------------------------
module conv_weight_loader
  import conv_ctrl_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                NUM_WORDS = 77
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  conv_weight_loader_if.slave  bus,
  input  logic                 act_valid_in,
  output logic                 act_valid_out,
  input  logic                 conv_rd_en,
  output logic                 act_rd_en,
  output logic                 busy,
  output logic                 load_done
`ifdef WEIGHT_CHECKSUM_EN
  ,
  output logic                 chk_err
`endif
);

  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NUM_WORDS - 1);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_LOAD  = ST_LOAD;
  localparam logic [2:0] S_RUN   = ST_RUN;
`ifdef WEIGHT_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = ST_CHECK;
  localparam logic [2:0] S_ERR   = ST_ERR;
`endif

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             beat, load_beat, last_beat, enter_load;

  assign beat       = bus.s_valid && bus.s_ready;
  assign load_beat  = beat && (state_q == S_LOAD);
  assign last_beat  = load_beat && (cnt_q == LAST_K);
  // Any transition into LOAD restarts the word count (start in IDLE/RUN/ERR).
  assign enter_load = (state_d == S_LOAD) && (state_q != S_LOAD);

`ifdef WEIGHT_CHECKSUM_EN
  logic csum_match;

  wload_csum #(.DATA_W(DATA_W)) u_csum (
    .clk    (clk),
    .rst    (rst),
    .clr    (enter_load),
    .acc_en (load_beat),
    .data   (bus.s_data),
    .match  (csum_match)
  );
`endif

  // NOTE: next-state is assigned its hold value first so every path through
  // the case drives it and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        if (last_beat) begin
`ifdef WEIGHT_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_RUN;
`endif
        end
      end
      S_RUN: begin
        if (start)      state_d = S_LOAD;
        else if (clear) state_d = S_IDLE;
      end
`ifdef WEIGHT_CHECKSUM_EN
      // The checksum beat is compared against the sum of all NUM_WORDS words.
      S_CHECK: if (beat) state_d = csum_match ? S_RUN : S_ERR;
      S_ERR:   if (start) state_d = S_LOAD;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (enter_load)     cnt_q <= '0;
      else if (load_beat) cnt_q <= cnt_q + 1'b1;
    end
  end

  // One write per accepted LOAD beat, one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.weight_wr_en   <= 1'b0;
      bus.weight_wr_data <= '0;
      bus.weight_wr_addr <= '0;
    end else begin
      bus.weight_wr_en <= load_beat;
      if (load_beat) begin
        bus.weight_wr_data <= bus.s_data;
        bus.weight_wr_addr <= BASE_ADDR + ADDR_W'(cnt_q);
      end
    end
  end

  // Decodes of the state register only; s_ready never looks at s_valid.
`ifdef WEIGHT_CHECKSUM_EN
  assign bus.s_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign chk_err     = (state_q == S_ERR);
`else
  assign bus.s_ready = (state_q == S_LOAD);
`endif
  assign busy          = bus.s_ready;
  assign load_done     = (state_q == S_RUN);
  assign act_valid_out = load_done && act_valid_in;
  assign act_rd_en     = load_done && conv_rd_en;

endmodule

// File: doc/conv_weight_loader.md
# conv_weight_loader

Controller that sequences one conv layer instance: it streams a layer's parameter words (kernels, biases, MACC coefficients) from an upstream word stream into the conv weight-write port at consecutive addresses, then opens the activation path into the conv. It sits between the parameter DMA/FIFO and the conv block, and between the activation FIFO and the conv `i_valid`/`fifo_rd_en` pair. Until loading completes, the conv sees no activation traffic.

## Interface
Parameters:
- `DATA_W`, 16, parameter word width; matches the conv `weight_wr_data` width.
- `ADDR_W`, 32, weight-write address width.
- `BASE_ADDR`, 0, address of the first parameter word.
- `NUM_WORDS`, 77, parameter words per layer: 72 kernel, 4 bias, 1 MACC coefficient. Must be ≥ 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: single-cycle pulse that begins a parameter load.
- `clear` in 1: single-cycle pulse that returns the block to IDLE from RUN.
- `s_data` in DATA_W: parameter word stream.
- `s_valid` in 1: qualifies `s_data`.
- `s_ready` out 1: accept; a beat transfers when `s_valid && s_ready`.
- `weight_wr_data` out DATA_W: to the conv.
- `weight_wr_addr` out ADDR_W: to the conv.
- `weight_wr_en` out 1: to the conv.
- `act_valid_in` in 1: activation FIFO not-empty / valid.
- `act_valid_out` out 1: drives the conv `i_valid`.
- `conv_rd_en` in 1: the conv `fifo_rd_en`.
- `act_rd_en` out 1: read enable to the activation FIFO.
- `busy` out 1: high in LOAD (and CHECK).
- `load_done` out 1: high in RUN.
- `chk_err` out 1: only present with `WEIGHT_CHECKSUM_EN`.

## Operation
- States: IDLE, LOAD, RUN, plus CHECK and ERR with `WEIGHT_CHECKSUM_EN`.
- IDLE: `s_ready`=0 and activation gated. `start` clears the word counter and moves to LOAD.
- LOAD: `s_ready`=1. Each accepted beat k (0-based) produces one write: data `s_data`, address `BASE_ADDR + k`.
- LOAD exit: after the beat with k = NUM_WORDS−1 is accepted, go to RUN (or CHECK when checksum is enabled).
- RUN: `act_valid_out = act_valid_in` and `act_rd_en = conv_rd_en`. In every other state both are forced to 0 combinationally.
- RUN, `clear`: go to IDLE.
- RUN, `start`: reload. Go to LOAD with the counter cleared; activation is gated from the next cycle.
- `start` in LOAD/CHECK is ignored. `clear` in IDLE/LOAD/CHECK is ignored.
- `start` and `clear` in the same cycle: `start` wins.
- `s_valid` outside LOAD/CHECK is not consumed, because `s_ready`=0.
- Counter width is `$clog2(NUM_WORDS+1)`. Address arithmetic is ADDR_W wide, unsigned, with no wrap check; BASE_ADDR+NUM_WORDS−1 must fit in ADDR_W.

## Timing
- Write path registered: a beat accepted in cycle t gives `weight_wr_en`=1 in cycle t+1, with that beat's data and address. `weight_wr_en` is high for exactly one cycle per beat; back-to-back beats give back-to-back writes.
- `s_ready` is a registered state decode and does not depend on `s_valid`.
- Last beat accepted at t: state = RUN at t+1, in the same cycle as the last `weight_wr_en`. `load_done`=1 and activation open from t+1.
- `start` at t: LOAD and `s_ready`=1 at t+1.
- `clear` at t: IDLE and activation gated at t+1.
- Reset values: state IDLE; all outputs 0 (`s_ready`, `weight_wr_*`, `act_*`, `busy`, `load_done`, `chk_err`).
- Reset mid-load: the partial load is discarded. The next `start` rewrites from BASE_ADDR.

## Configuration
- Macro: `WEIGHT_CHECKSUM_EN`.
- Defined:
  - A DATA_W-bit running sum (mod 2^DATA_W) of the NUM_WORDS words is accumulated in LOAD.
  - After the last word the block enters CHECK with `s_ready`=1 and accepts one more beat, the checksum word, which is not written to the conv.
  - Match: go to RUN one cycle after the checksum beat.
  - Mismatch: go to ERR with `chk_err`=1 and activation gated. ERR is left only by `start` (which clears `chk_err` and goes to LOAD) or by `rst`.
- Undefined: no CHECK/ERR states, no `chk_err` port, and RUN follows the last word directly.

## Structure
- Shared package `conv_ctrl_pkg`: state enum (IDLE, LOAD, RUN, CHECK, ERR) and the default widths DATA_W/ADDR_W.
- One sub-module, `wload_csum`: accumulator with clear, accumulate-enable and compare output. It is instantiated only under `WEIGHT_CHECKSUM_EN`.

## Test plan
- Basic load, NUM_WORDS=77, BASE_ADDR=0, continuous `s_valid`, words 0..76 → 77 consecutive writes, addr 0..76, data = word. `load_done` rises the cycle of the addr-76 write. `act_valid_out` follows `act_valid_in` thereafter.
- Bubbles: `s_valid` toggles every other cycle → writes only for accepted beats, addresses contiguous, no duplicates.
- Gating: `act_valid_in`=1 and `conv_rd_en`=1 during IDLE/LOAD → `act_valid_out`=0 and `act_rd_en`=0. `clear` in RUN → both 0 the next cycle.
- Reload: `start` in RUN → LOAD next cycle, writes restart at addr 0. `start` mid-LOAD → no effect, count continues.
- Reset after 40 words → all outputs 0. A new `start` loads 77 words from addr 0.
- Checksum (macro on): words 1..77, checksum 3003 (0x0BBB) → RUN. Checksum 0x0BBC → `chk_err`=1, activation stays gated, and `start` clears `chk_err`.
